// File: rtl/countdown_timer.sv
// Start/stop/pause countdown timer with a load-only reload register.
// Define COUNTDOWN_AUTORELOAD_EN for periodic reload on terminal count; otherwise one-shot into DONE.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             i_sysclk,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_start,
  input  logic             i_stop,
  output logic [WIDTH-1:0] o_count,
  output logic [1:0]       o_state,
  output logic             o_zero,
  output logic             o_done_stb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             done_stb_q;

  always_ff @(posedge i_sysclk) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      done_stb_q <= 1'b0;
    end else begin
      done_stb_q <= 1'b0;
      if (i_load) begin
        count_q  <= i_load_val;
        reload_q <= i_load_val;
        state_q  <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!i_stop && i_start && (count_q != '0)) state_q <= RUN;
          end
          RUN: begin
            // i_start while already running wins over i_en and has no effect.
            if (i_stop) begin
              state_q <= PAUSE;
            end else if (!i_start && i_en) begin
              if (count_q > WIDTH'(1)) begin
                count_q <= count_q - WIDTH'(1);
              end else begin
                done_stb_q <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                count_q <= reload_q;
`else
                count_q <= '0;
                state_q <= DONE;
`endif
              end
            end
          end
          PAUSE: begin
            if (!i_stop && i_start) state_q <= RUN;
          end
          DONE: begin
            if (i_stop) begin
              state_q <= IDLE;
              count_q <= '0;
            end else if (i_start && (reload_q != '0)) begin
              count_q <= reload_q;
              state_q <= RUN;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_count    = count_q;
  assign o_state    = state_q;
  assign o_done_stb = done_stb_q;
  assign o_zero     = (count_q == '0);

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter and load-value width in bits.
REQ-002 The block SHALL have port i_sysclk, input, 1 bit: fast system clock (~50 MHz); all state changes on its rising edge.
REQ-003 The block SHALL have port i_reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port i_en, input, 1 bit: count strobe (e.g. 1 Hz tick); one decrement per high cycle while running.
REQ-005 The block SHALL have port i_load, input, 1 bit: load request.
REQ-006 The block SHALL have port i_load_val, input, WIDTH bits: value captured on load.
REQ-007 The block SHALL have port i_start, input, 1 bit: start/resume/restart request.
REQ-008 The block SHALL have port i_stop, input, 1 bit: pause/clear request.
REQ-009 The block SHALL have port o_count, output, WIDTH bits: current count (registered).
REQ-010 The block SHALL have port o_state, output, 2 bits: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-011 The block SHALL have port o_zero, output, 1 bit: combinational, high when o_count==0.
REQ-012 The block SHALL have port o_done_stb, output, 1 bit: registered one-cycle pulse on terminal count.

Function
REQ-013 The block SHALL hold an internal WIDTH-bit reload register, written only by i_load.
REQ-014 Request priority SHALL be, highest first: reset, i_load, i_stop, i_start, i_en.
REQ-015 On i_load in any state: next cycle o_count=i_load_val, reload register=i_load_val, state IDLE, no decrement.
REQ-016 IDLE: i_start with o_count!=0 SHALL go to RUN; i_start with o_count==0 SHALL be ignored (stay IDLE); i_en SHALL be ignored.
REQ-017 RUN: i_en with o_count>1 SHALL decrement o_count by 1 next cycle.
REQ-018 RUN: i_en with o_count==1 is the terminal event: o_done_stb high for exactly the following cycle, behaviour per Configuration.
REQ-019 RUN: i_stop SHALL go to PAUSE, o_count frozen; an i_en in the same cycle SHALL NOT decrement.
REQ-020 PAUSE: i_start SHALL go to RUN without changing o_count; i_en and repeated i_stop SHALL be ignored.
REQ-021 DONE: o_count SHALL hold 0; i_start SHALL load o_count from the reload register and go to RUN if that value !=0, else remain DONE; i_stop SHALL go to IDLE with o_count=0.
REQ-022 Simultaneous i_start and i_stop SHALL act as i_stop alone.
REQ-023 o_count SHALL never wrap below 0; no decrement occurs outside RUN.
REQ-024 o_done_stb SHALL be asserted only as a consequence of REQ-018, never by load, start, or stop.

Reset
REQ-025 While i_reset_n is low at a clock edge: o_count=0, reload register=0, state IDLE, o_done_stb=0; o_zero consequently 1.
REQ-026 Reset mid-count SHALL abandon the countdown with no o_done_stb pulse, including when coincident with a terminal event.

Configuration
REQ-027 Macro COUNTDOWN_AUTORELOAD_EN SHALL select terminal-event behaviour.
REQ-028 Defined: on terminal event o_count SHALL load the reload register and state SHALL stay RUN (periodic mode); reload value 1 yields o_done_stb on every i_en.
REQ-029 Undefined: on terminal event o_count SHALL become 0 and state SHALL go to DONE (one-shot mode).

Verification
REQ-030 Reset, then load 3, start, three i_en pulses -> o_count 3,2,1,0; one-cycle o_done_stb after third i_en; one-shot: state DONE; autoreload: o_count=3, state RUN.
REQ-031 Load 5, start, i_en twice, i_stop together with i_en -> o_count=3, state PAUSE; i_en x4 -> still 3; i_start -> RUN, continues from 3.
REQ-032 Load 0, i_start -> stays IDLE, o_zero=1, no o_done_stb; load 255 (WIDTH=8), start, 255 i_en -> exactly one o_done_stb, no wrap to 255 in one-shot.
REQ-033 One-shot DONE after load 2: i_start -> o_count=2, RUN; i_stop in DONE -> IDLE, o_count=0.
REQ-034 Load 4, start, assert i_reset_n low coincident with i_en at o_count=1 -> o_count=0, IDLE, no o_done_stb.
REQ-035 In RUN with o_count=6, i_load=1 with i_load_val=9 and i_en/i_start/i_stop all high -> o_count=9, state IDLE.
